// File: rtl/moore_fsm.sv
// Serial detector for the bit pattern 101101 (MSB first, overlapping matches).
// z is a pure decode of the state register, so it never depends on x directly.
//
// state | meaning
// ------+----------------------------------
// S0    | idle, no prefix matched
// S1    | "1" matched
// S2    | "10" matched
// S3    | "101" matched
// S4    | "1011" matched
// S5    | "10110" matched
// S6    | "101101" matched, z asserted
module moore_fsm (
   input  logic Rst,
   input  logic Clk,
   input  logic x,
   output logic z
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5,
      S6 = 3'd6
   } state_t;

   state_t state;
   state_t state_nxt;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= S0;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = S0;
      case (state)
         S0:      state_nxt = x ? S1 : S0;
         S1:      state_nxt = x ? S1 : S2;
         S2:      state_nxt = x ? S3 : S0;
         S3:      state_nxt = x ? S4 : S2;
         S4:      state_nxt = x ? S1 : S5;
         S5:      state_nxt = x ? S6 : S0;
         // Keeping the "1011" suffix lets back-to-back matches overlap.
         S6:      state_nxt = x ? S4 : S2;
         default: state_nxt = S0;
      endcase
   end

   assign z = (state == S6);

endmodule

// File: tb/tb_moore_fsm.sv
// Bench for moore_fsm: a shift-register reference pushes the expected z for
// each sampling edge into a queue, which is popped and compared 1 unit later.
module tb_moore_fsm;

   logic Rst;
   logic Clk;
   logic x;
   logic z;

   int   checks;
   int   failures;
   logic armed;
   logic [5:0] hist;
   logic exp_q[$];

   moore_fsm dut (
      .Rst (Rst),
      .Clk (Clk),
      .x   (x),
      .z   (z)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: z=%b expected %b", tag, $time, obs, exp);
      end
   endtask

   // Reference: z after an edge is 1 exactly when the last six bits sampled
   // since reset read 101101.
   always @(posedge Clk or posedge Rst) begin
      if (Rst || !armed) begin
         hist = 6'b0;
      end else begin
         hist = {hist[4:0], x};
         exp_q.push_back(hist == 6'b101101);
      end
   end

   always @(posedge Clk) begin
      #1;
      if (exp_q.size() > 0) check("z_edge", z, exp_q.pop_front());
   end

   task automatic send_seq(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge Clk);
         x = bits[i];
      end
      @(posedge Clk);
      #2;
   endtask

   // Reset pulse entirely inside a low phase, so no clock edge sees Rst high.
   task automatic pulse_reset(input string tag);
      #1;
      Rst = 1'b1;
      #1;
      check(tag, z, 1'b0);
      #1;
      Rst = 1'b0;
   endtask

   int   sched_t[12] = '{12, 22, 32, 42, 54, 64, 74, 84, 96, 106, 116, 126};
   logic sched_v[12] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1};

   initial begin
      checks   = 0;
      failures = 0;
      armed    = 1'b0;
      Rst      = 1'b1;
      x        = 1'bx;

      // Reset hold with x unknown.
      #1  check("reset_t1", z, 1'b0);
      #6  check("reset_t7", z, 1'b0);
      #5  x = sched_v[0];
      #1  check("reset_t13", z, 1'b0);
      #2  Rst = 1'b0;
      #5  armed = 1'b1;

      // Single detection from the timed stimulus table.
      for (int i = 1; i < 12; i++) begin
         #(sched_t[i] - int'($time));
         x = sched_v[i];
      end
      @(posedge Clk);
      #2;

      // Overlap: pulses after the 6th and 9th bits.
      @(negedge Clk);
      pulse_reset("rst_before_overlap");
      send_seq(16'b1011011011, 10);

      // Near misses.
      @(negedge Clk);
      pulse_reset("rst_before_miss1");
      send_seq(16'b10110010110, 11);
      @(negedge Clk);
      pulse_reset("rst_before_miss2");
      send_seq(16'b1011100, 7);

      // Async reset mid-pattern: progress lost, then 1 -> S1; 01101 completes from S1.
      @(negedge Clk);
      pulse_reset("rst_before_mid");
      send_seq(16'b10110, 5);
      @(negedge Clk);
      pulse_reset("rst_mid_pattern");
      send_seq(16'b1, 1);
      send_seq(16'b01101, 5);

      // Reset while z is high drops z at once; 01101 must not detect from S0.
      @(negedge Clk);
      pulse_reset("rst_before_hi");
      send_seq(16'b101101, 6);
      Rst = 1'b1;
      #1;
      check("rst_while_z_hi", z, 1'b0);
      #1;
      Rst = 1'b0;
      send_seq(16'b01101, 5);

      #20;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
